// File: rtl/ifetch_queue.sv
// Instruction-fetch unit with a decoupling queue.
// Owns the fetch PC, issues word reads to a synchronous instruction ROM with
// one cycle of read latency, and buffers each returned {instr, pc} pair in a
// small circular queue that decode drains through a valid/ready handshake.
// A redirect from execute restarts fetch at a new target and discards every
// queued entry and any read still in flight.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 14,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    // Instruction ROM
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    // Redirect from execute
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    // Decode side
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_link,
    // Observability
    output logic [XLEN-1:0]            fetch_pc,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy limits at the two widths they are compared at.
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(QDEPTH);

    // Sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Fetch-side state
    logic                  inflight;       // a read was issued last cycle
    logic                  inflight_kill;  // that read belongs to a flushed stream
    logic [XLEN-1:0]       inflight_pc;    // PC of the read whose data returns now

    // Queue state
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [XLEN-1:0]       q_instr [QDEPTH];
    logic [XLEN-1:0]       q_pc    [QDEPTH];

    // Per-cycle decisions
    logic [CNT_W:0]        occupancy;
    logic                  has_room;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [XLEN-1:0]       target_aligned;
    logic                  unused_target_bits;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign target_aligned     = {redirect_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];

    // Entries already queued plus the one possibly returning this cycle must
    // leave a free slot. The registered count is used, so a pop happening in
    // this same cycle does not earn extra credit; that keeps the request path
    // free of the decode-side ready.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign has_room  = (occupancy < DEPTH_LIM);
    assign issue     = !reset && !redirect_valid && has_room;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc[ADDR_W+1:2];

    // A returning read is kept unless it was killed or a redirect flushes now.
    assign push      = inflight && !inflight_kill && !redirect_valid;

    assign out_valid = (count != '0);

    // A redirect discards the head, so a simultaneous handshake is ignored.
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign q_count   = count;

    // Head entry drives decode; all head outputs read as zero when empty.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        out_link  = '0;
        if (out_valid) begin
            out_instr = q_instr[rd_ptr];
            out_pc    = q_pc[rd_ptr];
            out_link  = pc_next(q_pc[rd_ptr]);
        end
    end

    // Fetch PC and in-flight tracking; redirect overrides sequential issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_kill <= 1'b0;
        end else if (redirect_valid) begin
            // No issue happens in a redirect cycle; anything still marked
            // in flight from here on belongs to the old stream.
            fetch_pc      <= target_aligned;
            inflight      <= 1'b0;
            inflight_kill <= 1'b1;
        end else begin
            inflight      <= issue;
            inflight_kill <= 1'b0;
            if (issue) begin
                fetch_pc <= pc_next(fetch_pc);
            end
        end
    end

    // PC of the outstanding read, carried alongside the ROM latency.
    always_ff @(posedge clock) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the returning ROM word is paired with its PC.
    always_ff @(posedge clock) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

    // The issue rule reserves a slot for every read, so a push into a full
    // queue without a matching pop means the credit accounting is broken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && !pop && (count == DEPTH_CNT)));
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a randomized stream checked
// against an in-order PC model. Two instances: defaults, and a QDEPTH=2
// instance that starts near the top of the address space.
module tb_ifetch_queue;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Instance 0: default parameters
    logic        req0;
    logic [13:0] addr0;
    logic [31:0] rdata0;
    logic        redir0 = 1'b0;
    logic [31:0] target0 = '0;
    logic        valid0;
    logic        ready0 = 1'b0;
    logic [31:0] instr0, pc0, link0, fpc0;
    logic [2:0]  cnt0;

    // Instance 1: RESET_PC near wrap, QDEPTH=2
    logic        req1;
    logic [13:0] addr1;
    logic [31:0] rdata1;
    logic        redir1 = 1'b0;
    logic [31:0] target1 = '0;
    logic        valid1;
    logic        ready1 = 1'b0;
    logic [31:0] instr1, pc1, link1, fpc1;
    logic [1:0]  cnt1;

    ifetch_queue u0 (
        .clock(clock), .reset(reset),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .redirect_valid(redir0), .redirect_target(target0),
        .out_valid(valid0), .out_ready(ready0),
        .out_instr(instr0), .out_pc(pc0), .out_link(link0),
        .fetch_pc(fpc0), .q_count(cnt0)
    );

    ifetch_queue #(.XLEN(32), .ADDR_W(14), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u1 (
        .clock(clock), .reset(reset),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redir1), .redirect_target(target1),
        .out_valid(valid1), .out_ready(ready1),
        .out_instr(instr1), .out_pc(pc1), .out_link(link1),
        .fetch_pc(fpc1), .q_count(cnt1)
    );

    // Synchronous ROMs, one cycle latency: word n holds n.
    always @(posedge clock) if (req0) rdata0 <= {18'd0, addr0};
    always @(posedge clock) if (req1) rdata1 <= {18'd0, addr1};

    // Expected instruction for a byte PC (14-bit word address, word n = n).
    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return {18'd0, pc[15:2]};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        redir0 = 1'b0; ready0 = 1'b0; target0 = '0;
        redir1 = 1'b0; ready1 = 1'b0; target1 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redir0 = 1'b0; ready0 = 1'b0; target0 = '0;
        redir1 = 1'b0; ready1 = 1'b0; target1 = '0;
        repeat (2) @(negedge clock);
        checks++; if (fpc0 !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got %h want %h", fpc0, 32'h0); end
        checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", req0); end
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", valid0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d want 0", cnt0); end
        checks++; if ({instr0, pc0, link0} !== 96'h0) begin errors++; $display("FAIL reset_head got %h/%h/%h want 0/0/0", instr0, pc0, link0); end
        checks++; if (fpc1 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_fetch_pc_u1 got %h want %h", fpc1, 32'hFFFF_FFF8); end
        checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_q_count_u1 got %0d want 0", cnt1); end
        reset = 1'b0;
        #1;
        checks++; if (req0 !== 1'b1 || addr0 !== 14'h0) begin errors++; $display("FAIL first_request got req=%b addr=%h want req=1 addr=0", req0, addr0); end
        checks++; if (addr1 !== 14'h3FFE) begin errors++; $display("FAIL first_addr_u1 got %h want 3ffe", addr1); end
    endtask

    // Runs directly after test_reset: latency of the very first fetch.
    task automatic test_first_fetch();
        logic [31:0] exp;
        ready0 = 1'b1;
        @(negedge clock);
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL first_cycle1_valid got %b want 0", valid0); end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h0 || instr0 !== 32'h0 || link0 !== 32'h4) begin
            errors++; $display("FAIL first_output got v=%b pc=%h instr=%h link=%h want v=1 pc=0 instr=0 link=4", valid0, pc0, instr0, link0);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            exp = 32'(4 * k);
            checks++; if (valid0 !== 1'b1 || pc0 !== exp || instr0 !== rom_word(exp) || link0 !== exp + 32'd4) begin
                errors++; $display("FAIL stream_%0d got v=%b pc=%h instr=%h link=%h want pc=%h", k, valid0, pc0, instr0, link0, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        apply_reset();
        repeat (8) @(negedge clock);
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d want 4", cnt0); end
        checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b want 0", req0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (valid0 !== 1'b1 || pc0 !== 32'h0 || instr0 !== 32'h0 || cnt0 !== 3'd4) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=0 instr=0 cnt=4", i, valid0, pc0, instr0, cnt0);
            end
        end
        ready0 = 1'b1;
        #1;
        checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL bp_no_credit_same_cycle got %b want 0", req0); end
        exp = 32'h0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (valid0 !== 1'b1 || pc0 !== exp || instr0 !== rom_word(exp)) begin
                errors++; $display("FAIL bp_drain_%0d got v=%b pc=%h instr=%h want pc=%h", i, valid0, pc0, instr0, exp);
            end
            exp += 32'd4;
            @(negedge clock);
            if (i == 0) begin
                checks++; if (cnt0 !== 3'd3 || req0 !== 1'b1) begin
                    errors++; $display("FAIL bp_resume got cnt=%0d req=%b want cnt=3 req=1", cnt0, req0);
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        apply_reset();
        repeat (3) @(negedge clock);
        checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL redir_pre_count got %0d want 2", cnt0); end
        redir0 = 1'b1;
        target0 = 32'h40;
        #1;
        checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %b want 0", req0); end
        @(negedge clock);
        redir0 = 1'b0;
        checks++; if (cnt0 !== 3'd0 || valid0 !== 1'b0) begin errors++; $display("FAIL redir_flush got cnt=%0d v=%b want 0/0", cnt0, valid0); end
        #1;
        checks++; if (req0 !== 1'b1 || addr0 !== 14'h10 || fpc0 !== 32'h40) begin
            errors++; $display("FAIL redir_issue got req=%b addr=%h fpc=%h want 1/10/40", req0, addr0, fpc0);
        end
        @(negedge clock);
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL redir_r2_valid got %b want 0", valid0); end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h40 || instr0 !== 32'h10 || link0 !== 32'h44) begin
            errors++; $display("FAIL redir_first got v=%b pc=%h instr=%h link=%h want 1/40/10/44", valid0, pc0, instr0, link0);
        end
        ready0 = 1'b1;
        exp = 32'h40;
        for (int i = 0; i < 6; i++) begin
            checks++; if (valid0 !== 1'b1 || pc0 !== exp) begin
                errors++; $display("FAIL redir_seq_%0d got v=%b pc=%h want pc=%h", i, valid0, pc0, exp);
            end
            exp += 32'd4;
            @(negedge clock);
        end
    endtask

    task automatic test_redirect_pop();
        apply_reset();
        ready0 = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h8) begin errors++; $display("FAIL rp_pre got v=%b pc=%h want 1/8", valid0, pc0); end
        redir0 = 1'b1;
        target0 = 32'h103;
        @(negedge clock);
        redir0 = 1'b0;
        checks++; if (valid0 !== 1'b0 || cnt0 !== 3'd0) begin errors++; $display("FAIL rp_flush got v=%b cnt=%0d want 0/0", valid0, cnt0); end
        @(negedge clock);
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rp_r2_valid got %b want 0", valid0); end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h100 || instr0 !== 32'h40 || link0 !== 32'h104) begin
            errors++; $display("FAIL rp_first got v=%b pc=%h instr=%h link=%h want 1/100/40/104", valid0, pc0, instr0, link0);
        end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h104) begin errors++; $display("FAIL rp_second got v=%b pc=%h want 1/104", valid0, pc0); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        int          got;
        bit          saw_wrap;
        apply_reset();
        ready1 = 1'b1;
        exp = 32'hFFFF_FFF8;
        got = 0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (req1 && fpc1 == 32'h0 && !saw_wrap) begin
                saw_wrap = 1'b1;
                checks++; if (addr1 !== 14'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", addr1); end
            end
            if (valid1 && ready1) begin
                checks++; if (pc1 !== exp || instr1 !== rom_word(exp) || link1 !== exp + 32'd4) begin
                    errors++; $display("FAIL wrap_out_%0d got pc=%h instr=%h link=%h want pc=%h", got, pc1, instr1, link1, exp);
                end
                exp += 32'd4;
                got++;
            end
            @(negedge clock);
        end
        checks++; if (got < 5) begin errors++; $display("FAIL wrap_progress got %0d outputs want at least 5", got); end
        checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_seen got 0 want 1"); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        repeat (8) @(negedge clock);
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL mid_full got %0d want 4", cnt0); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cnt0 !== 3'd0 || valid0 !== 1'b0 || fpc0 !== 32'h0 || req0 !== 1'b0 || pc0 !== 32'h0) begin
            errors++; $display("FAIL mid_async got cnt=%0d v=%b fpc=%h req=%b pc=%h want all 0", cnt0, valid0, fpc0, req0, pc0);
        end
        @(negedge clock);
        reset = 1'b0;
        ready0 = 1'b1;
        @(negedge clock);
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL mid_restart_c1 got %b want 0", valid0); end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h0 || instr0 !== 32'h0) begin
            errors++; $display("FAIL mid_restart_c2 got v=%b pc=%h instr=%h want 1/0/0", valid0, pc0, instr0);
        end
        @(negedge clock);
        checks++; if (valid0 !== 1'b1 || pc0 !== 32'h4) begin errors++; $display("FAIL mid_restart_c3 got v=%b pc=%h want 1/4", valid0, pc0); end
    endtask

    // Randomized ready/redirect traffic. Model: the stream is the sequence of
    // word PCs starting at the last reset/redirect target, delivered in order
    // with no gaps; the head always shows the next undelivered PC, and the
    // first instruction at a redirect target is visible three cycles later.
    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] rtarget;
        int          since;
        apply_reset();
        exp = 32'h0;
        rtarget = 32'h0;
        since = -1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (since >= 0) since++;
            checks++; if (valid0 !== (cnt0 != 3'd0) || cnt0 > 3'd4) begin
                errors++; $display("FAIL rnd_count_%0d got v=%b cnt=%0d", cyc, valid0, cnt0);
            end
            if (valid0) begin
                checks++; if (pc0 !== exp || instr0 !== rom_word(exp) || link0 !== exp + 32'd4) begin
                    errors++; $display("FAIL rnd_head_%0d got pc=%h instr=%h link=%h want pc=%h", cyc, pc0, instr0, link0, exp);
                end
            end
            if (since == 1 || since == 2) begin
                checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rnd_flush_%0d got v=%b want 0", cyc, valid0); end
            end
            if (since == 3) begin
                checks++; if (valid0 !== 1'b1 || pc0 !== rtarget) begin
                    errors++; $display("FAIL rnd_redir_lat_%0d got v=%b pc=%h want 1/%h", cyc, valid0, pc0, rtarget);
                end
                since = -1;
            end
            if (cnt0 == 3'd4) begin
                checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL rnd_full_req_%0d got %b want 0", cyc, req0); end
            end
            ready0  = ($urandom_range(0, 3) != 0);
            redir0  = ($urandom_range(0, 15) == 0);
            target0 = $urandom;
            #1;
            if (redir0) begin
                checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL rnd_redir_req_%0d got %b want 0", cyc, req0); end
                exp = {target0[31:2], 2'b00};
                rtarget = exp;
                since = 0;
            end else if (valid0 && ready0) begin
                exp += 32'd4;
            end
            @(negedge clock);
        end
        redir0 = 1'b0;
        ready0 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
